// File: rtl/npu_fsm_pkg.sv
// Shared types for the NPU loop-nest controller.
// Fixed state encoding and the control-strobe bundle.
package npu_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HMODE = 3'd1,
    VMODE = 3'd2,
    PIPE  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } npu_state_t;

  typedef struct packed {
    logic en_npu;
    logic en_hmode;
    logic en_vmode;
    logic ldh_v_n;
    logic wr_pipe;
    logic en_p;
    logic en_st;
    logic wr_mem;
    logic done;
  } npu_ctrl_t;

endpackage

// File: rtl/npu_fsm.sv
// Loop-nest sequencer for the conv engine; Moore outputs, one cycle after the deciding edge.
// No backpressure: advances only on dp terminal-count flags. Option: NPU_FSM_DONE_STICKY_EN.
module npu_fsm
  import npu_fsm_pkg::*;
(
  input  logic ck,
  input  logic rst,
  input  logic start,
  input  logic s_tc_hmode,
  input  logic s_tc_vmode,
  input  logic s_tc_res,
  input  logic s_tc_L0,
  input  logic s_tc_L1,
  input  logic s_tc_L2,
  input  logic s_tc_L3,
  input  logic s_tc_L4,
  output logic ctrl_en_npu,
  output logic ctrl_en_hmode,
  output logic ctrl_en_vmode,
  output logic ctrl_ldh_v_n,
  output logic ctrl_wr_pipe,
  output logic ctrl_en_p,
  output logic ctrl_en_st,
  output logic ctrl_wr_mem,
  output logic done
);

  npu_state_t state_q;
  npu_state_t state_d;
  npu_ctrl_t  ctrl;
  logic       outer_tc;

  assign outer_tc = s_tc_L2 & s_tc_L3 & s_tc_L4;

  always_ff @(posedge ck) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = HMODE;
      HMODE: if (s_tc_hmode) state_d = VMODE;
      VMODE: if (s_tc_vmode) state_d = s_tc_L0 ? PIPE : HMODE;
      PIPE:  state_d = s_tc_L1 ? STORE : HMODE;
      STORE: if (s_tc_res) state_d = outer_tc ? DONE : HMODE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      HMODE: begin
        ctrl.en_npu   = 1'b1;
        ctrl.en_hmode = 1'b1;
        ctrl.ldh_v_n  = 1'b1;
      end
      VMODE: begin
        ctrl.en_npu   = 1'b1;
        ctrl.en_vmode = 1'b1;
      end
      PIPE: begin
        ctrl.wr_pipe = 1'b1;
        ctrl.en_p    = 1'b1;
      end
      STORE: begin
        ctrl.en_st  = 1'b1;
        ctrl.wr_mem = 1'b1;
      end
      DONE:    ctrl.done = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign ctrl_en_npu   = ctrl.en_npu;
  assign ctrl_en_hmode = ctrl.en_hmode;
  assign ctrl_en_vmode = ctrl.en_vmode;
  assign ctrl_ldh_v_n  = ctrl.ldh_v_n;
  assign ctrl_wr_pipe  = ctrl.wr_pipe;
  assign ctrl_en_p     = ctrl.en_p;
  assign ctrl_en_st    = ctrl.en_st;
  assign ctrl_wr_mem   = ctrl.wr_mem;

`ifdef NPU_FSM_DONE_STICKY_EN
  // Holds completion visible in IDLE until the next launch is accepted.
  logic done_hold_q;

  always_ff @(posedge ck) begin
    if (!rst)                          done_hold_q <= 1'b0;
    else if (state_q == DONE)          done_hold_q <= 1'b1;
    else if (state_q == IDLE && start) done_hold_q <= 1'b0;
  end

  assign done = ctrl.done | ((state_q == IDLE) & done_hold_q);
`else
  assign done = ctrl.done;
`endif

endmodule

// File: tb/tb_npu_fsm.sv
// Scoreboard bench for npu_fsm: expected strobe vectors queued at drive time, compared at the next negedge.
// Build with NPU_FSM_DONE_STICKY_EN to check the held-done variant.
module tb_npu_fsm;

  logic ck = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic s_tc_hmode = 1'b0, s_tc_vmode = 1'b0, s_tc_res = 1'b0;
  logic s_tc_L0 = 1'b0, s_tc_L1 = 1'b0, s_tc_L2 = 1'b0, s_tc_L3 = 1'b0, s_tc_L4 = 1'b0;
  logic ctrl_en_npu, ctrl_en_hmode, ctrl_en_vmode, ctrl_ldh_v_n;
  logic ctrl_wr_pipe, ctrl_en_p, ctrl_en_st, ctrl_wr_mem, done;

  int checks = 0;
  int errors = 0;

  // {en_npu, en_hmode, en_vmode, ldh_v_n, wr_pipe, en_p, en_st, wr_mem, done}
  localparam logic [8:0] O_I = 9'b000000000;
  localparam logic [8:0] O_H = 9'b110100000;
  localparam logic [8:0] O_V = 9'b101000000;
  localparam logic [8:0] O_P = 9'b000011000;
  localparam logic [8:0] O_S = 9'b000000110;
  localparam logic [8:0] O_D = 9'b000000001;
`ifdef NPU_FSM_DONE_STICKY_EN
  localparam logic [8:0] O_IA = 9'b000000001;
`else
  localparam logic [8:0] O_IA = 9'b000000000;
`endif

  // flag vector {hmode, vmode, res, L0, L1, L2, L3, L4}
  localparam logic [7:0] T_ALL  = 8'hFF;
  localparam logic [7:0] T_NONE = 8'h00;
  localparam logic [7:0] T_HM   = 8'b1000_0000;
  localparam logic [7:0] T_VM   = 8'b0100_0000;
  localparam logic [7:0] T_RES  = 8'b0010_0000;
  localparam logic [7:0] T_L0   = 8'b0001_0000;
  localparam logic [7:0] T_L1   = 8'b0000_1000;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  sb_t sb[$];

  wire [8:0] obs = {ctrl_en_npu, ctrl_en_hmode, ctrl_en_vmode, ctrl_ldh_v_n,
                    ctrl_wr_pipe, ctrl_en_p, ctrl_en_st, ctrl_wr_mem, done};

  npu_fsm dut (
    .ck(ck), .rst(rst), .start(start),
    .s_tc_hmode(s_tc_hmode), .s_tc_vmode(s_tc_vmode), .s_tc_res(s_tc_res),
    .s_tc_L0(s_tc_L0), .s_tc_L1(s_tc_L1), .s_tc_L2(s_tc_L2),
    .s_tc_L3(s_tc_L3), .s_tc_L4(s_tc_L4),
    .ctrl_en_npu(ctrl_en_npu), .ctrl_en_hmode(ctrl_en_hmode),
    .ctrl_en_vmode(ctrl_en_vmode), .ctrl_ldh_v_n(ctrl_ldh_v_n),
    .ctrl_wr_pipe(ctrl_wr_pipe), .ctrl_en_p(ctrl_en_p),
    .ctrl_en_st(ctrl_en_st), .ctrl_wr_mem(ctrl_wr_mem), .done(done)
  );

  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic compare_head();
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  // One clock: check last cycle's expectation, drive inputs, queue what the next edge must yield.
  task automatic step(input logic r, input logic s, input logic [7:0] tc,
                      input logic [8:0] exp, input string tag);
    sb_t e;
    @(negedge ck);
    compare_head();
    rst = r;
    start = s;
    {s_tc_hmode, s_tc_vmode, s_tc_res, s_tc_L0, s_tc_L1, s_tc_L2, s_tc_L3, s_tc_L4} = tc;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic min_layer(input string tag, input logic hold_start);
    step(1, 1,          T_ALL, O_H, {tag, "_h"});
    step(1, hold_start, T_ALL, O_V, {tag, "_v"});
    step(1, hold_start, T_ALL, O_P, {tag, "_p"});
    step(1, hold_start, T_ALL, O_S, {tag, "_s"});
    step(1, hold_start, T_ALL, O_D, {tag, "_done"});
    step(1, hold_start, T_ALL, O_IA, {tag, "_idle"});
  endtask

  initial begin
    // reset with start asserted, then launch
    step(0, 1, T_ALL, O_I, "rst_0");
    step(0, 1, T_ALL, O_I, "rst_1");
    step(1, 1, T_NONE, O_H, "launch");
    step(1, 0, T_NONE, O_H, "h_wait");
    step(1, 0, T_ALL, O_V, "h_to_v");
    step(1, 0, T_ALL, O_P, "v_to_p");
    step(1, 0, T_ALL, O_S, "p_to_s");
    step(1, 0, T_ALL, O_D, "s_to_done");
    step(1, 0, T_ALL, O_IA, "done_to_idle");

    // minimal layer: done on the 5th edge after start
    min_layer("min", 1'b0);

    // idle dwell; flags must be ignored and sticky done must persist
    for (int i = 0; i < 10; i++) step(1, 0, T_ALL, O_IA, "idle_dwell");

    // inner loop: two HMODE/VMODE rounds; flags for other states ignored in HMODE
    step(1, 1, T_NONE, O_H, "in_launch");
    step(1, 0, 8'b0111_1111, O_H, "in_h1");
    step(1, 0, 8'b0111_1111, O_H, "in_h2");
    step(1, 0, T_HM, O_V, "in_h3");
    step(1, 0, T_L0 | T_L1, O_V, "in_v1");
    step(1, 0, T_VM, O_H, "in_v2_l0lo");
    step(1, 0, T_NONE, O_H, "in_r2_h1");
    step(1, 0, T_NONE, O_H, "in_r2_h2");
    step(1, 0, T_HM, O_V, "in_r2_h3");
    step(1, 0, T_NONE, O_V, "in_r2_v1");
    step(1, 0, T_VM | T_L0, O_P, "in_r2_v2");
    step(1, 0, T_NONE, O_H, "pipe_1cyc");

    // outer loop: L4 low at STORE exit returns to HMODE
    step(1, 0, T_HM, O_V, "out_h");
    step(1, 0, T_VM | T_L0, O_P, "out_v");
    step(1, 0, T_L1, O_S, "out_p");
    step(1, 0, 8'b0001_1111, O_S, "out_s1");
    step(1, 0, T_NONE, O_S, "out_s2");
    step(1, 0, 8'b0011_1110, O_H, "out_s3_l4lo");
    step(1, 0, T_HM, O_V, "out2_h");
    step(1, 0, T_VM | T_L0, O_P, "out2_v");
    step(1, 0, T_L1, O_S, "out2_p");
    step(1, 0, T_ALL, O_D, "out2_s");
    step(1, 0, T_NONE, O_IA, "out2_done");

    // abort from STORE: immediate IDLE, no done
    step(1, 1, T_ALL, O_H, "ab_h");
    step(1, 0, T_ALL, O_V, "ab_v");
    step(1, 0, T_ALL, O_P, "ab_p");
    step(1, 0, T_ALL, O_S, "ab_s");
    step(0, 0, T_NONE, O_I, "ab_rst");
    step(1, 0, T_ALL, O_I, "ab_idle1");
    step(1, 0, T_ALL, O_I, "ab_idle2");

    // two back-to-back layers; second holds start so it relaunches after DONE
    min_layer("lay1", 1'b0);
    min_layer("lay2", 1'b1);
    step(1, 1, T_NONE, O_H, "relaunch");
    step(1, 1, T_NONE, O_H, "start_ignored");

    @(negedge ck);
    compare_head();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
